// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: a LEN-bit shift history compared against a live pattern,
// with a Mealy hit, its registered copy, and a saturating hit counter with a sticky flag.
module pattern_detector #(
    parameter int LEN     = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic [LEN-1:0]   pattern,
    input  logic             clr_cnt,
    output logic             hit,
    output logic             hit_q,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int               FILL_W   = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
    localparam logic [FILL_W-1:0] ARM_AT   = FILL_W'(LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam bit                DROP_ON_MATCH = (OVERLAP == 0);

    // The fill counter is the state; the enum only names its two regions.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    state_t            state;
    logic [LEN-1:0]    hist;
    logic [LEN-1:0]    window;
    logic [FILL_W-1:0] fill;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        window = {hist[LEN-2:0], din};
        state  = (fill >= ARM_AT) ? ARMED : FILLING;
        hit    = !reset && en && (state == ARMED) && (window == pattern);
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window;
            if (hit && DROP_ON_MATCH)
                fill <= '0;
            else if (fill != FILL_MAX)
                fill <= fill + FILL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hit_q <= 1'b0;
        else
            hit_q <= hit;
    end

    // Clear wins over a simultaneous hit; sat rises on the edge count reaches its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr_cnt) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (hit && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
            if (count == CNT_MAX - CNT_W'(1))
                sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: three instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream; expected values are hand-computed per step.
module tb_pattern_detector;

    logic       clk;
    logic       reset;
    logic       en;
    logic       din;
    logic [3:0] pattern;
    logic       clr_cnt;

    logic       hit_a, hit_q_a, sat_a;
    logic [7:0] count_a;
    logic       hit_b, hit_q_b, sat_b;
    logic [7:0] count_b;
    logic       hit_c, hit_q_c, sat_c;
    logic [1:0] count_c;

    int vectors     = 0;
    int miscompares = 0;

    pattern_detector #(.LEN(4), .CNT_W(8), .OVERLAP(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .din(din), .pattern(pattern), .clr_cnt(clr_cnt),
        .hit(hit_a), .hit_q(hit_q_a), .count(count_a), .sat(sat_a)
    );

    pattern_detector #(.LEN(4), .CNT_W(8), .OVERLAP(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .din(din), .pattern(pattern), .clr_cnt(clr_cnt),
        .hit(hit_b), .hit_q(hit_q_b), .count(count_b), .sat(sat_b)
    );

    pattern_detector #(.LEN(4), .CNT_W(2), .OVERLAP(1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .din(din), .pattern(pattern), .clr_cnt(clr_cnt),
        .hit(hit_c), .hit_q(hit_q_c), .count(count_c), .sat(sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a rising edge; combinational hit is sampled at the falling edge.
    task automatic drive(input logic e, input logic d);
        en  = e;
        din = d;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; hit is checked while reset is held with en=1.
    task automatic pulse_reset();
        reset = 1'b1;
        en    = 1'b1;
        din   = 1'b1;
        #1;
        check("rst_hit",   16'(hit_a),   16'd0);
        check("rst_count", 16'(count_a), 16'd0);
        check("rst_hit_q", 16'(hit_q_a), 16'd0);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
    endtask

    logic [6:0] s29;
    logic [6:0] h29_a;
    logic [6:0] h29_b;
    logic [1:0] cexp [8];
    logic       sexp [8];

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        din     = 1'b0;
        pattern = 4'b1011;
        clr_cnt = 1'b0;
        #12;
        check("init_hit",   16'(hit_a),   16'd0);
        check("init_hit_q", 16'(hit_q_a), 16'd0);
        check("init_count", 16'(count_a), 16'd0);
        check("init_sat",   16'(sat_a),   16'd0);
        reset = 1'b0;
        tick();

        // Basic detection of 1011
        drive(1'b1, 1'b1); check("b28_hit1", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b0); check("b28_hit2", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b1); check("b28_hit3", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b1); check("b28_hit4", 16'(hit_a), 16'd1);
        check("b28_hit_q_same", 16'(hit_q_a), 16'd0);
        tick();
        drive(1'b0, 1'b0);
        check("b28_hit_q5", 16'(hit_q_a), 16'd1);
        check("b28_count",  16'(count_a), 16'd1);
        tick();
        check("b28_hit_q6", 16'(hit_q_a), 16'd0);

        // Overlapping vs discarding history on the same stream
        pulse_reset();
        tick();
        s29   = 7'b1011011;   // first bit in s29[6]
        h29_a = 7'b0001001;
        h29_b = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, s29[i]);
            check($sformatf("ovl1_hit_bit%0d", 7 - i), 16'(hit_a), 16'(h29_a[i]));
            check($sformatf("ovl0_hit_bit%0d", 7 - i), 16'(hit_b), 16'(h29_b[i]));
            tick();
        end
        check("ovl1_count", 16'(count_a), 16'd2);
        check("ovl0_count", 16'(count_b), 16'd1);

        // Enable gap: en=0 must freeze history and suppress hit
        pulse_reset();
        tick();
        drive(1'b1, 1'b1); tick();
        drive(1'b1, 1'b0); tick();
        drive(1'b0, 1'b1); check("gap_hit1", 16'(hit_a), 16'd0); tick();
        drive(1'b0, 1'b1); check("gap_hit2", 16'(hit_a), 16'd0); tick();
        drive(1'b0, 1'b0); check("gap_hit3", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b1); check("gap_hit4", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b1); check("gap_hit5", 16'(hit_a), 16'd1); tick();
        drive(1'b0, 1'b0);
        check("gap_count", 16'(count_a), 16'd1);

        // Counter saturation with CNT_W=2 on a run of ones
        tick();
        pulse_reset();
        tick();
        pattern = 4'b1111;
        cexp = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        sexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1);
            check($sformatf("sat_hit_bit%0d", i + 1), 16'(hit_c), (i >= 3) ? 16'd1 : 16'd0);
            tick();
            check($sformatf("sat_count_bit%0d", i + 1), 16'(count_c), 16'(cexp[i]));
            check($sformatf("sat_flag_bit%0d", i + 1),  16'(sat_c),   16'(sexp[i]));
        end
        check("sat_count_wide", 16'(count_a), 16'd5);
        check("sat_count_novl", 16'(count_b), 16'd2);
        check("sat_flag_wide",  16'(sat_a),   16'd0);
        en      = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_count", 16'(count_c), 16'd0);
        check("clr_sat",   16'(sat_c),   16'd0);
        check("clr_count_wide", 16'(count_a), 16'd0);
        // History survives clr_cnt: one more 1 completes 1111 again
        drive(1'b1, 1'b1);
        check("clr_keeps_hist", 16'(hit_c), 16'd1);
        tick();

        // Mid-stream reset discards partial history
        pattern = 4'b1011;
        pulse_reset();
        tick();
        drive(1'b1, 1'b1); tick();
        drive(1'b1, 1'b0); tick();
        drive(1'b1, 1'b1); tick();
        pulse_reset();
        drive(1'b1, 1'b1); check("mrst_hit1", 16'(hit_a), 16'd0); tick();
        check("mrst_count", 16'(count_a), 16'd0);
        drive(1'b1, 1'b0); check("mrst_hit2", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b1); check("mrst_hit3", 16'(hit_a), 16'd0); tick();
        drive(1'b1, 1'b1); check("mrst_hit4", 16'(hit_a), 16'd1); tick();
        check("mrst_count2", 16'(count_a), 16'd1);

        // clr_cnt coincident with a hit at count=2
        drive(1'b1, 1'b0); tick();
        drive(1'b1, 1'b1); tick();
        drive(1'b1, 1'b1); check("cc_hit_pre", 16'(hit_a), 16'd1); tick();
        check("cc_count_pre", 16'(count_a), 16'd2);
        drive(1'b1, 1'b0); tick();
        drive(1'b1, 1'b1); tick();
        clr_cnt = 1'b1;
        drive(1'b1, 1'b1);
        check("cc_hit", 16'(hit_a), 16'd1);
        tick();
        clr_cnt = 1'b0;
        check("cc_hit_q",  16'(hit_q_a), 16'd1);
        check("cc_count",  16'(count_a), 16'd0);

        // Live pattern change: history ends ...011, next bit 0 gives window 0110
        drive(1'b1, 1'b0);
        check("pat_old", 16'(hit_a), 16'd0);
        pattern = 4'b0110;
        #1;
        check("pat_new", 16'(hit_a), 16'd1);
        tick();
        check("pat_count", 16'(count_a), 16'd1);
        drive(1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL provide parameter LEN, default 4, pattern length in bits (legal 2..16).
REQ-002 The block SHALL provide parameter CNT_W, default 8, width of the hit counter (legal 1..16).
REQ-003 The block SHALL provide parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = history discarded after each match.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  1  din valid this cycle; when 0 no state changes except via clr_cnt.
REQ-007 Port din  input  1  serial data bit.
REQ-008 Port pattern  input  LEN  target pattern; pattern[LEN-1] is the earliest bit received, pattern[0] the latest; sampled live every cycle.
REQ-009 Port clr_cnt  input  1  synchronous clear of count and sat.
REQ-010 Port hit  output  1  Mealy match indication, combinational, same cycle as the completing bit.
REQ-011 Port hit_q  output  1  registered copy of hit, one cycle later.
REQ-012 Port count  output  CNT_W  number of matches since reset/clear, saturating.
REQ-013 Port sat  output  1  sticky flag, count has reached 2^CNT_W-1.

Function
REQ-014 The block SHALL hold a LEN-bit history register hist; on a cycle with en=1 it SHALL update to {hist[LEN-2:0], din}.
REQ-015 The block SHALL hold a fill counter of valid history bits, range 0..LEN, incremented on en=1 and saturating at LEN.
REQ-016 The fill counter SHALL act as the state: FILLING while fill < LEN-1; ARMED while fill >= LEN-1.
REQ-017 hit SHALL equal en AND (fill >= LEN-1) AND ({hist[LEN-2:0], din} == pattern); hit SHALL be 0 whenever en=0.
REQ-018 With OVERLAP=1, a match SHALL NOT alter fill; with OVERLAP=0, a match SHALL set fill to 0 on the next edge (hist still shifts).
REQ-019 hit_q SHALL be registered from hit at every rising edge regardless of en.
REQ-020 On a cycle with hit=1 and clr_cnt=0, count SHALL increment by 1 unless already 2^CNT_W-1, in which case it SHALL hold.
REQ-021 sat SHALL be set on the edge at which count becomes 2^CNT_W-1 and SHALL remain set until clr_cnt or reset.
REQ-022 clr_cnt=1 SHALL set count to 0 and sat to 0 on the next edge, taking priority over a simultaneous hit (that hit is not counted but still drives hit and hit_q).
REQ-023 clr_cnt SHALL NOT affect hist or fill.
REQ-024 A change of pattern SHALL take effect in the same cycle's hit evaluation; no history is discarded.

Reset
REQ-025 On reset assertion, hist, fill, count, hit_q and sat SHALL go to 0 immediately, independent of clk.
REQ-026 While reset is asserted, hit SHALL be 0 and en, din and clr_cnt SHALL be ignored.
REQ-027 Reset asserted mid-stream SHALL discard all partial history; detection restarts from fill=0 after deassertion.

Verification
REQ-028 LEN=4, pattern=4'b1011, en=1, din 1,0,1,1 -> hit=1 only in 4th cycle, hit_q=1 in 5th, count=1.
REQ-029 OVERLAP=1, din 1,0,1,1,0,1,1 -> hit on bits 4 and 7, count=2; OVERLAP=0, same stream -> hit on bit 4 only, count=1.
REQ-030 din 1,0 then en=0 for 3 cycles (din toggling) then 1,1 with en=1 -> hit=0 throughout the gap, hit=1 on the final bit, count=1.
REQ-031 CNT_W=2, OVERLAP=1, pattern=4'b1111, 8 consecutive 1s -> 5 hits, count=3, sat=1 from the 3rd hit onward; then clr_cnt=1 -> count=0, sat=0.
REQ-032 din 1,0,1, reset pulsed between clock edges, then 1 -> no hit, count=0, fill=1; then 0,1,1 -> hit on last bit.
REQ-033 clr_cnt=1 in the same cycle as a hit with count=2 -> hit=1, hit_q=1 next cycle, count=0 after the edge.
